// File: rtl/sisc_ctrl_hs.sv
// sisc_ctrl_hs: multi-cycle SISC control sequencer with memory handshake.
// Walks START/FETCH/DECODE/EXECUTE/MEM/WB/WB2 and parks in HALT or FAULT.
// Memory states stall on mem_rdy. A watchdog moves the FSM to FAULT when
// mem_rdy stays low for too long.
module sisc_ctrl_hs #(
  parameter int                STATW  = 4,
  parameter int                TMO_W  = 4,
  parameter logic [STATW-1:0]  AM_IMM = STATW'(8)
) (
  input  logic             clk,
  input  logic             rst_f,
  input  logic [3:0]       opcode,
  input  logic [STATW-1:0] mm,
  input  logic [STATW-1:0] stat,
  input  logic             mem_rdy,
  output logic             rf_we,
  output logic             wb_sel,
  output logic [1:0]       alu_op,
  output logic             br_sel,
  output logic             pc_rst,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             rb_sel,
  output logic             ir_load,
  output logic             mm_sel,
  output logic             dm_we,
  output logic             mem_req,
  output logic             halted,
  output logic             fault
);

  localparam logic [3:0] OP_NOOP = 4'd0;
  localparam logic [3:0] OP_LOD  = 4'd1;
  localparam logic [3:0] OP_STR  = 4'd2;
  localparam logic [3:0] OP_SWP  = 4'd3;
  localparam logic [3:0] OP_BRA  = 4'd4;
  localparam logic [3:0] OP_BRR  = 4'd5;
  localparam logic [3:0] OP_BNE  = 4'd6;
  localparam logic [3:0] OP_BNR  = 4'd7;
  localparam logic [3:0] OP_ALU  = 4'd8;
  localparam logic [3:0] OP_HLT  = 4'd15;

  typedef enum logic [3:0] {
    S_START   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXECUTE = 4'd3,
    S_MEM     = 4'd4,
    S_WB      = 4'd5,
    S_WB2     = 4'd6,
    S_HALT    = 4'd7,
    S_FAULT   = 4'd8
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [TMO_W-1:0] wait_cnt;

  logic is_branch;
  logic br_taken;
  logic alu_imm;
  logic tmo;

  // Branch evaluation: BRA/BRR take on any masked flag set, BNE/BNR on none.
  always_comb begin
    is_branch = (opcode == OP_BRA) || (opcode == OP_BRR) ||
                (opcode == OP_BNE) || (opcode == OP_BNR);
    br_taken  = 1'b0;
    if ((opcode == OP_BRA) || (opcode == OP_BRR))
      br_taken = ((mm & stat) != '0);
    else if ((opcode == OP_BNE) || (opcode == OP_BNR))
      br_taken = ((mm & stat) == '0);
    alu_imm = (opcode == OP_ALU) && (mm == AM_IMM);
    tmo     = (wait_cnt == {TMO_W{1'b1}});
  end

  // State register and stall watchdog; the counter restarts on every state change.
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state    <= S_START;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if (next_state != state)
        wait_cnt <= '0;
      else if (mem_req && !mem_rdy)
        wait_cnt <= wait_cnt + TMO_W'(1);
    end
  end

  // Next-state decode; mem_rdy on the last watchdog cycle still advances normally.
  always_comb begin
    next_state = state;
    case (state)
      S_START:  next_state = S_FETCH;
      S_FETCH: begin
        if (mem_rdy)  next_state = S_DECODE;
        else if (tmo) next_state = S_FAULT;
      end
      S_DECODE: begin
        if (opcode == OP_HLT)
          next_state = S_HALT;
        else if (is_branch || (opcode == OP_NOOP) || (opcode > OP_ALU))
          next_state = S_FETCH;
        else
          next_state = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (opcode == OP_ALU)
          next_state = S_WB;
        else if ((opcode == OP_LOD) || (opcode == OP_STR) || (opcode == OP_SWP))
          next_state = S_MEM;
        else
          next_state = S_FETCH;
      end
      S_MEM: begin
        if (mem_rdy)  next_state = (opcode == OP_STR) ? S_FETCH : S_WB;
        else if (tmo) next_state = S_FAULT;
      end
      S_WB:     next_state = (opcode == OP_SWP) ? S_WB2 : S_FETCH;
      S_WB2:    next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      S_FAULT:  next_state = S_FAULT;
      default:  next_state = S_START;
    endcase
  end

  // Output decode: Moore strobes per state, plus the mem_rdy-qualified fetch load.
  always_comb begin
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    alu_op   = 2'b10;
    br_sel   = 1'b0;
    pc_rst   = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    rb_sel   = 1'b0;
    ir_load  = 1'b0;
    mm_sel   = 1'b0;
    dm_we    = 1'b0;
    mem_req  = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;
    case (state)
      S_START:  pc_rst = 1'b1;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_rdy) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
        end
      end
      S_DECODE: begin
        if (is_branch && br_taken) begin
          pc_write = 1'b1;
          pc_sel   = 1'b1;
          br_sel   = (opcode == OP_BRA) || (opcode == OP_BNE);
        end
      end
      S_EXECUTE: alu_op = alu_imm ? 2'b01 : 2'b00;
      S_MEM: begin
        alu_op  = alu_imm ? 2'b11 : 2'b10;
        mem_req = 1'b1;
        mm_sel  = 1'b1;
        dm_we   = (opcode == OP_STR);
      end
      S_WB: begin
        rf_we  = 1'b1;
        wb_sel = (opcode == OP_LOD) || (opcode == OP_SWP);
      end
      S_WB2: begin
        rf_we  = 1'b1;
        rb_sel = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sisc_ctrl_hs.sv
// Scoreboard bench for sisc_ctrl_hs: the driver pushes the expected output
// vector for every cycle it drives, and a monitor pops and compares on negedge.
module tb_sisc_ctrl_hs;

  logic       clk = 1'b0;
  logic       rst_f = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic [3:0] mm = 4'd0;
  logic [3:0] stat = 4'd0;
  logic       mem_rdy = 1'b0;
  logic       rf_we, wb_sel, br_sel, pc_rst, pc_write, pc_sel, rb_sel;
  logic       ir_load, mm_sel, dm_we, mem_req, halted, fault;
  logic [1:0] alu_op;

  sisc_ctrl_hs #(.STATW(4), .TMO_W(4), .AM_IMM(4'd8)) dut (
    .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
    .mem_rdy(mem_rdy), .rf_we(rf_we), .wb_sel(wb_sel), .alu_op(alu_op),
    .br_sel(br_sel), .pc_rst(pc_rst), .pc_write(pc_write), .pc_sel(pc_sel),
    .rb_sel(rb_sel), .ir_load(ir_load), .mm_sel(mm_sel), .dm_we(dm_we),
    .mem_req(mem_req), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  // Bit order: rf_we wb_sel alu_op[1:0] br_sel pc_rst pc_write pc_sel
  //            rb_sel ir_load mm_sel dm_we mem_req halted fault
  localparam logic [14:0] X_START = 15'h1200;
  localparam logic [14:0] X_FWAIT = 15'h1004;
  localparam logic [14:0] X_FRDY  = 15'h1124;
  localparam logic [14:0] X_DEC   = 15'h1000;
  localparam logic [14:0] X_BABS  = 15'h1580;
  localparam logic [14:0] X_BREL  = 15'h1180;
  localparam logic [14:0] X_EIMM  = 15'h0800;
  localparam logic [14:0] X_EREG  = 15'h0000;
  localparam logic [14:0] X_MEM   = 15'h1014;
  localparam logic [14:0] X_MSTR  = 15'h101C;
  localparam logic [14:0] X_WBM   = 15'h7000;
  localparam logic [14:0] X_WBA   = 15'h5000;
  localparam logic [14:0] X_WB2   = 15'h5040;
  localparam logic [14:0] X_HALT  = 15'h1002;
  localparam logic [14:0] X_FLT   = 15'h1001;

  logic [14:0] exp_q[$];
  string       name_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  logic [14:0] act;
  assign act = {rf_we, wb_sel, alu_op, br_sel, pc_rst, pc_write, pc_sel,
                rb_sel, ir_load, mm_sel, dm_we, mem_req, halted, fault};

  // Monitor: one expected vector per driven cycle, checked mid-cycle.
  initial begin
    logic [14:0] e;
    string       nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        vectors++;
        if (act !== e) begin
          miscompares++;
          $display("FAIL %s: got %h expected %h", nm, act, e);
        end
      end
    end
  end

  task automatic step(input logic r, input logic [3:0] op, input logic [3:0] m,
                      input logic [3:0] s, input logic rdy,
                      input logic [14:0] e, input string nm);
    @(posedge clk);
    #1;
    rst_f   = r;
    opcode  = op;
    mm      = m;
    stat    = s;
    mem_rdy = rdy;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic fetch_ok(input logic [3:0] op);
    step(1'b1, op, 4'd0, 4'd0, 1'b1, X_FRDY, "fetch");
  endtask

  initial begin
    // Reset and first fetch
    step(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, X_START, "reset_start");
    step(1'b1, 4'd0, 4'd0, 4'd0, 1'b1, X_START, "start_pcrst");
    fetch_ok(4'd0);

    // Branches
    step(1'b1, 4'd4, 4'd2, 4'd2, 1'b1, X_BABS, "bra_taken");
    fetch_ok(4'd4);
    step(1'b1, 4'd4, 4'd2, 4'd0, 1'b1, X_DEC, "bra_not_taken");
    fetch_ok(4'd4);
    step(1'b1, 4'd7, 4'd2, 4'd1, 1'b1, X_BREL, "bnr_taken");
    fetch_ok(4'd7);
    step(1'b1, 4'd6, 4'd2, 4'd2, 1'b1, X_DEC, "bne_not_taken");
    fetch_ok(4'd6);
    step(1'b1, 4'd5, 4'hC, 4'h4, 1'b1, X_BREL, "brr_taken");
    fetch_ok(4'd5);

    // ALU immediate and register modes
    step(1'b1, 4'd8, 4'd8, 4'd0, 1'b1, X_DEC, "alu_imm_dec");
    step(1'b1, 4'd8, 4'd8, 4'd0, 1'b1, X_EIMM, "alu_imm_exec");
    step(1'b1, 4'd8, 4'd8, 4'd0, 1'b1, X_WBA, "alu_imm_wb");
    fetch_ok(4'd8);
    step(1'b1, 4'd8, 4'd3, 4'd0, 1'b1, X_DEC, "alu_reg_dec");
    step(1'b1, 4'd8, 4'd3, 4'd0, 1'b1, X_EREG, "alu_reg_exec");
    step(1'b1, 4'd8, 4'd3, 4'd0, 1'b1, X_WBA, "alu_reg_wb");
    fetch_ok(4'd8);

    // SWP with a three-cycle memory stall
    step(1'b1, 4'd3, 4'd0, 4'd0, 1'b1, X_DEC, "swp_dec");
    step(1'b1, 4'd3, 4'd0, 4'd0, 1'b1, X_EREG, "swp_exec");
    for (int i = 0; i < 3; i++)
      step(1'b1, 4'd3, 4'd0, 4'd0, 1'b0, X_MEM, "swp_mem_stall");
    step(1'b1, 4'd3, 4'd0, 4'd0, 1'b1, X_MEM, "swp_mem_rdy");
    step(1'b1, 4'd3, 4'd0, 4'd0, 1'b1, X_WBM, "swp_wb");
    step(1'b1, 4'd3, 4'd0, 4'd0, 1'b1, X_WB2, "swp_wb2");
    fetch_ok(4'd3);

    // STR and LOD with zero-wait memory
    step(1'b1, 4'd2, 4'd0, 4'd0, 1'b1, X_DEC, "str_dec");
    step(1'b1, 4'd2, 4'd0, 4'd0, 1'b1, X_EREG, "str_exec");
    step(1'b1, 4'd2, 4'd0, 4'd0, 1'b1, X_MSTR, "str_mem");
    fetch_ok(4'd2);
    step(1'b1, 4'd1, 4'd0, 4'd0, 1'b1, X_DEC, "lod_dec");
    step(1'b1, 4'd1, 4'd0, 4'd0, 1'b1, X_EREG, "lod_exec");
    step(1'b1, 4'd1, 4'd0, 4'd0, 1'b1, X_MEM, "lod_mem");
    step(1'b1, 4'd1, 4'd0, 4'd0, 1'b1, X_WBM, "lod_wb");
    fetch_ok(4'd1);

    // NOOP and an unused opcode return straight to FETCH
    step(1'b1, 4'd0, 4'd0, 4'd0, 1'b1, X_DEC, "noop_dec");
    fetch_ok(4'd0);
    step(1'b1, 4'd9, 4'd0, 4'd0, 1'b1, X_DEC, "op9_dec");

    // mem_rdy on the last watchdog cycle wins, in FETCH and in MEM
    for (int i = 0; i < 15; i++)
      step(1'b1, 4'd9, 4'd0, 4'd0, 1'b0, X_FWAIT, "fetch_stall15");
    step(1'b1, 4'd9, 4'd0, 4'd0, 1'b1, X_FRDY, "fetch_rdy_at_limit");
    step(1'b1, 4'd1, 4'd0, 4'd0, 1'b1, X_DEC, "lod2_dec");
    step(1'b1, 4'd1, 4'd0, 4'd0, 1'b1, X_EREG, "lod2_exec");
    for (int i = 0; i < 15; i++)
      step(1'b1, 4'd1, 4'd0, 4'd0, 1'b0, X_MEM, "mem_stall15");
    step(1'b1, 4'd1, 4'd0, 4'd0, 1'b1, X_MEM, "mem_rdy_at_limit");
    step(1'b1, 4'd1, 4'd0, 4'd0, 1'b1, X_WBM, "lod2_wb");

    // Timeout in FETCH, then reset out of FAULT
    for (int i = 0; i < 16; i++)
      step(1'b1, 4'd1, 4'd0, 4'd0, 1'b0, X_FWAIT, "fetch_stall16");
    step(1'b1, 4'd1, 4'd0, 4'd0, 1'b1, X_FLT, "fault_entry");
    step(1'b1, 4'd1, 4'd0, 4'd0, 1'b1, X_FLT, "fault_hold");
    step(1'b0, 4'd1, 4'd0, 4'd0, 1'b1, X_FLT, "fault_rst_asserted");
    step(1'b1, 4'd1, 4'd0, 4'd0, 1'b1, X_START, "fault_to_start");
    fetch_ok(4'd1);

    // HALT, then reset out of HALT
    step(1'b1, 4'd15, 4'd0, 4'd0, 1'b1, X_DEC, "hlt_dec");
    for (int i = 0; i < 3; i++)
      step(1'b1, 4'd15, 4'd0, 4'd0, 1'b1, X_HALT, "halt_hold");
    step(1'b0, 4'd15, 4'd0, 4'd0, 1'b1, X_HALT, "halt_rst_asserted");
    step(1'b1, 4'd15, 4'd0, 4'd0, 1'b1, X_START, "halt_to_start");
    fetch_ok(4'd15);

    // Reset in the middle of a MEM stall
    step(1'b1, 4'd1, 4'd0, 4'd0, 1'b1, X_DEC, "lod3_dec");
    step(1'b1, 4'd1, 4'd0, 4'd0, 1'b1, X_EREG, "lod3_exec");
    step(1'b1, 4'd1, 4'd0, 4'd0, 1'b0, X_MEM, "lod3_mem_stall");
    step(1'b1, 4'd1, 4'd0, 4'd0, 1'b0, X_MEM, "lod3_mem_stall");
    step(1'b0, 4'd1, 4'd0, 4'd0, 1'b0, X_MEM, "mem_rst_asserted");
    step(1'b1, 4'd1, 4'd0, 4'd0, 1'b1, X_START, "mem_rst_start");
    fetch_ok(4'd1);
    step(1'b1, 4'd0, 4'd0, 4'd0, 1'b1, X_DEC, "final_noop_dec");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++)
      @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d vectors left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
